// File: rtl/sbr_dispatcher.sv
// ============================================================================
// Module   : sbr_dispatcher
// Brief    : Scans sbr_table and issues one bank-dispatch descriptor per SBR,
//            highest request total first. Option macro: SBR_DISP_SKIP_EMPTY_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef MAX_SBR_ENTRIES
`define MAX_SBR_ENTRIES 8
`endif
`ifndef SBR_ID_WIDTH
`define SBR_ID_WIDTH 4
`endif
`ifndef REQUEST_ID_WIDTH
`define REQUEST_ID_WIDTH 8
`endif
`ifndef SRR_ID_WIDTH
`define SRR_ID_WIDTH 6
`endif
`ifndef BANK_GROUP_WIDTH
`define BANK_GROUP_WIDTH 2
`endif
`ifndef BANK_WIDTH
`define BANK_WIDTH 2
`endif

module sbr_dispatcher #(
    parameter int MAX_ENTRIES = `MAX_SBR_ENTRIES
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    input  logic [`SBR_ID_WIDTH-1:0]       sbr_num_entries,
    output logic [`SBR_ID_WIDTH-1:0]       sbr_rd_addr,
    input  logic [`REQUEST_ID_WIDTH-1:0]   sbr_rd_total,
    input  logic [`SRR_ID_WIDTH-1:0]       sbr_rd_row_count,
    input  logic [`SRR_ID_WIDTH-1:0]       sbr_rd_head,
    input  logic [`SRR_ID_WIDTH-1:0]       sbr_rd_tail,
    input  logic [`BANK_GROUP_WIDTH-1:0]   sbr_rd_bg,
    input  logic [`BANK_WIDTH-1:0]         sbr_rd_bank,
    output logic                           sbr_clear,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [`SBR_ID_WIDTH-1:0]       out_sbr_id,
    output logic [`BANK_GROUP_WIDTH-1:0]   out_bg,
    output logic [`BANK_WIDTH-1:0]         out_bank,
    output logic [`REQUEST_ID_WIDTH-1:0]   out_total,
    output logic [`SRR_ID_WIDTH-1:0]       out_row_count,
    output logic [`SRR_ID_WIDTH-1:0]       out_head,
    output logic [`SRR_ID_WIDTH-1:0]       out_tail,
    output logic [`SBR_ID_WIDTH-1:0]       issued_count
);
    localparam int c_id_w = `SBR_ID_WIDTH;
    localparam logic [c_id_w-1:0] c_one = c_id_w'(1);
    localparam logic [c_id_w-1:0] c_max = c_id_w'(MAX_ENTRIES);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_scan  = 3'd1;
    localparam logic [2:0] c_eval  = 3'd2;
    localparam logic [2:0] c_issue = 3'd3;
    localparam logic [2:0] c_flush = 3'd4;

    logic [2:0]                       r_state, w_state_nx;
    logic [c_id_w-1:0]                r_n, r_idx, r_eval_addr, r_issued, r_best_id, w_num;
    logic                             r_eval_vld, r_have_best, r_out_valid;
    logic [MAX_ENTRIES-1:0]           r_served, w_served_nx, w_range, w_addr_onehot;
    logic [`REQUEST_ID_WIDTH-1:0]     r_best_total;
    logic [`SRR_ID_WIDTH-1:0]         r_best_row, r_best_head, r_best_tail;
    logic [`BANK_GROUP_WIDTH-1:0]     r_best_bg;
    logic [`BANK_WIDTH-1:0]           r_best_bank;
    logic                             w_cand, w_fire, w_remain, w_scan_last, w_have_best_nx;

    assign w_num          = (sbr_num_entries > c_max) ? c_max : sbr_num_entries;
    assign w_scan_last    = (r_idx == r_n - c_one);
    assign w_fire         = r_out_valid && out_ready;
    assign w_addr_onehot  = MAX_ENTRIES'(1) << r_eval_addr;
    assign w_served_nx    = r_served | (MAX_ENTRIES'(1) << r_best_id);
    assign w_remain       = |(~w_served_nx & w_range);
    assign w_have_best_nx = r_have_best || w_cand;

    always_comb begin
        w_range = '0;
        for (int i = 0; i < MAX_ENTRIES; i++) begin
            w_range[i] = (c_id_w'(i) < r_n);
        end
    end

    // Read data lags the address by one cycle, so SCAN/EVAL judge entry r_eval_addr.
    always_comb begin
        w_cand = 1'b0;
        if ((r_state == c_scan || r_state == c_eval) && r_eval_vld &&
            ((r_served & w_addr_onehot) == '0)) begin
            w_cand = !r_have_best || (sbr_rd_total > r_best_total);
        end
`ifdef SBR_DISP_SKIP_EMPTY_EN
        if (sbr_rd_total == '0) begin
            w_cand = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // ISSUE spends one bubble cycle (out_valid low) after each accepted descriptor before rescanning.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_idle:  if (start) w_state_nx = (sbr_num_entries == '0) ? c_flush : c_scan;
            c_scan:  if (w_scan_last) w_state_nx = c_eval;
            c_eval:  w_state_nx = w_have_best_nx ? c_issue : c_flush;
            c_issue: begin
                if (!r_out_valid) begin
                    w_state_nx = c_scan;
                end else if (w_fire) begin
                    w_state_nx = w_remain ? c_issue : c_flush;
                end
            end
            c_flush: w_state_nx = c_idle;
            default: w_state_nx = c_idle;
        endcase
    end

    always_comb begin
        busy      = (r_state != c_idle);
        done      = (r_state == c_flush);
        sbr_clear = (r_state == c_flush);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n          <= '0;
            r_idx        <= '0;
            r_eval_addr  <= '0;
            r_eval_vld   <= 1'b0;
            r_issued     <= '0;
            r_served     <= '0;
            r_have_best  <= 1'b0;
            r_out_valid  <= 1'b0;
            r_best_id    <= '0;
            r_best_total <= '0;
            r_best_row   <= '0;
            r_best_head  <= '0;
            r_best_tail  <= '0;
            r_best_bg    <= '0;
            r_best_bank  <= '0;
        end else begin
            r_eval_vld  <= (r_state == c_scan);
            r_eval_addr <= r_idx;
            case (r_state)
                c_idle: begin
                    if (start && sbr_num_entries != '0) begin
                        r_n         <= w_num;
                        r_served    <= '0;
                        r_issued    <= '0;
                        r_idx       <= '0;
                        r_have_best <= 1'b0;
                    end
                end
                c_scan:  if (!w_scan_last) r_idx <= r_idx + c_one;
                c_eval:  if (w_have_best_nx) r_out_valid <= 1'b1;
                c_issue: begin
                    if (w_fire) begin
                        r_out_valid <= 1'b0;
                        r_served    <= w_served_nx;
                        r_issued    <= r_issued + c_one;
                        r_have_best <= 1'b0;
                        r_idx       <= '0;
                    end
                end
                default: ;
            endcase
            if (w_cand) begin
                r_have_best  <= 1'b1;
                r_best_id    <= r_eval_addr;
                r_best_total <= sbr_rd_total;
                r_best_row   <= sbr_rd_row_count;
                r_best_head  <= sbr_rd_head;
                r_best_tail  <= sbr_rd_tail;
                r_best_bg    <= sbr_rd_bg;
                r_best_bank  <= sbr_rd_bank;
            end
        end
    end

    assign sbr_rd_addr   = r_idx;
    assign out_valid     = r_out_valid;
    assign out_sbr_id    = r_best_id;
    assign out_bg        = r_best_bg;
    assign out_bank      = r_best_bank;
    assign out_total     = r_best_total;
    assign out_row_count = r_best_row;
    assign out_head      = r_best_head;
    assign out_tail      = r_best_tail;
    assign issued_count  = r_issued;

endmodule

`default_nettype wire

// File: tb/tb_sbr_dispatcher.sv
// ============================================================================
// Module   : tb_sbr_dispatcher
// Brief    : Self-checking bench for sbr_dispatcher with a sorted-order model.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef MAX_SBR_ENTRIES
`define MAX_SBR_ENTRIES 8
`endif
`ifndef SBR_ID_WIDTH
`define SBR_ID_WIDTH 4
`endif
`ifndef REQUEST_ID_WIDTH
`define REQUEST_ID_WIDTH 8
`endif
`ifndef SRR_ID_WIDTH
`define SRR_ID_WIDTH 6
`endif
`ifndef BANK_GROUP_WIDTH
`define BANK_GROUP_WIDTH 2
`endif
`ifndef BANK_WIDTH
`define BANK_WIDTH 2
`endif

module tb_sbr_dispatcher;
    localparam int MAXE = `MAX_SBR_ENTRIES;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic                          start = 1'b0;
    logic                          busy, done, sbr_clear, out_valid;
    logic                          out_ready = 1'b0;
    logic [`SBR_ID_WIDTH-1:0]      sbr_num_entries = '0;
    logic [`SBR_ID_WIDTH-1:0]      sbr_rd_addr, out_sbr_id, issued_count;
    logic [`REQUEST_ID_WIDTH-1:0]  sbr_rd_total = '0;
    logic [`SRR_ID_WIDTH-1:0]      sbr_rd_row_count = '0, sbr_rd_head = '0, sbr_rd_tail = '0;
    logic [`BANK_GROUP_WIDTH-1:0]  sbr_rd_bg = '0;
    logic [`BANK_WIDTH-1:0]        sbr_rd_bank = '0;
    logic [`BANK_GROUP_WIDTH-1:0]  out_bg;
    logic [`BANK_WIDTH-1:0]        out_bank;
    logic [`REQUEST_ID_WIDTH-1:0]  out_total;
    logic [`SRR_ID_WIDTH-1:0]      out_row_count, out_head, out_tail;

    logic [`REQUEST_ID_WIDTH-1:0]  t_total [MAXE];
    logic [`SRR_ID_WIDTH-1:0]      t_row [MAXE], t_head [MAXE], t_tail [MAXE];
    logic [`BANK_GROUP_WIDTH-1:0]  t_bg [MAXE];
    logic [`BANK_WIDTH-1:0]        t_bank [MAXE];

    int checks = 0;
    int errors = 0;
    int clr_cnt = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    sbr_dispatcher #(.MAX_ENTRIES(MAXE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .sbr_num_entries(sbr_num_entries), .sbr_rd_addr(sbr_rd_addr),
        .sbr_rd_total(sbr_rd_total), .sbr_rd_row_count(sbr_rd_row_count),
        .sbr_rd_head(sbr_rd_head), .sbr_rd_tail(sbr_rd_tail), .sbr_rd_bg(sbr_rd_bg),
        .sbr_rd_bank(sbr_rd_bank), .sbr_clear(sbr_clear), .out_valid(out_valid),
        .out_ready(out_ready), .out_sbr_id(out_sbr_id), .out_bg(out_bg), .out_bank(out_bank),
        .out_total(out_total), .out_row_count(out_row_count), .out_head(out_head),
        .out_tail(out_tail), .issued_count(issued_count)
    );

    // Table read port with one cycle of registered latency.
    always @(posedge clk) begin
        sbr_rd_total     <= t_total[sbr_rd_addr];
        sbr_rd_row_count <= t_row[sbr_rd_addr];
        sbr_rd_head      <= t_head[sbr_rd_addr];
        sbr_rd_tail      <= t_tail[sbr_rd_addr];
        sbr_rd_bg        <= t_bg[sbr_rd_addr];
        sbr_rd_bank      <= t_bank[sbr_rd_addr];
        if (sbr_clear === 1'b1) clr_cnt <= clr_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_entry(input int i, input int total);
        t_total[i] = `REQUEST_ID_WIDTH'(total);
        t_row[i]   = `SRR_ID_WIDTH'($urandom);
        t_head[i]  = `SRR_ID_WIDTH'($urandom);
        t_tail[i]  = `SRR_ID_WIDTH'($urandom);
        t_bg[i]    = `BANK_GROUP_WIDTH'($urandom);
        t_bank[i]  = `BANK_WIDTH'($urandom);
    endtask

    function automatic logic [63:0] exp_fields(input int e);
        return 64'({`SBR_ID_WIDTH'(e), t_bg[e], t_bank[e], t_total[e], t_row[e], t_head[e], t_tail[e]});
    endfunction

    function automatic logic [63:0] dut_fields();
        return 64'({out_sbr_id, out_bg, out_bank, out_total, out_row_count, out_head, out_tail});
    endfunction

    // Expected issue order: descending total, ascending index among equal totals.
    task automatic build_expected(input int n);
        bit keep;
        int pos;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            keep = 1'b1;
`ifdef SBR_DISP_SKIP_EMPTY_EN
            if (t_total[i] == '0) keep = 1'b0;
`endif
            if (keep) begin
                pos = 0;
                while (pos < exp_q.size() && t_total[exp_q[pos]] >= t_total[i]) pos++;
                exp_q.insert(pos, i);
            end
        end
    endtask

    // ready_mode: 0 = always high, 1 = random, 2 = low for 10 cycles on the first descriptor.
    task automatic run_epoch(input string name, input int n, input int ready_mode);
        int cyc, fired, first_lat, hold, clr0, expect_cnt, e;
        bit seen_done;
        logic [63:0] snap;
        build_expected(n);
        expect_cnt = exp_q.size();
        clr0 = clr_cnt; fired = 0; first_lat = -1; hold = 0; seen_done = 1'b0; snap = '0;
        @(negedge clk);
        sbr_num_entries = `SBR_ID_WIDTH'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sbr_num_entries = `SBR_ID_WIDTH'($urandom);
        check({name, "/busy"}, 64'(busy), 64'(1));
        cyc = 0;
        while (!seen_done && cyc < 3000) begin
            if (done === 1'b1) begin
                seen_done = 1'b1;
                start = 1'b0;
                check({name, "/clear_with_done"}, 64'(sbr_clear), 64'(1));
                check({name, "/fired"}, 64'(fired), 64'(expect_cnt));
                check({name, "/issued_count"}, 64'(issued_count), 64'(expect_cnt));
                if (n == 0) check({name, "/done_latency"}, 64'(cyc), 64'(0));
                if (ready_mode == 0 && n > 0 && expect_cnt == n)
                    check({name, "/epoch_len"}, 64'(cyc + 2), 64'(n * (n + 3) + 1));
            end else begin
                if (out_valid === 1'b1 && first_lat < 0) begin
                    first_lat = cyc + 1;
                    snap = dut_fields();
                    check({name, "/first_latency"}, 64'(first_lat), 64'(n + 2));
                end
                start = ($urandom_range(0, 5) == 0);
                case (ready_mode)
                    0: out_ready = 1'b1;
                    1: out_ready = 1'($urandom_range(0, 1));
                    default: begin
                        if (out_valid === 1'b1 && fired == 0 && hold < 10) begin
                            out_ready = 1'b0;
                            check({name, "/hold_stable"}, dut_fields(), snap);
                            hold++;
                        end else begin
                            out_ready = 1'b1;
                        end
                    end
                endcase
                if (out_valid === 1'b1 && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check({name, "/unexpected_descriptor"}, 64'(out_sbr_id), 64'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check({name, "/sbr_id"}, 64'(out_sbr_id), 64'(e));
                        check({name, "/total"}, 64'(out_total), 64'(t_total[e]));
                        check({name, "/fields"}, dut_fields(), exp_fields(e));
                    end
                    check({name, "/issued_before_fire"}, 64'(issued_count), 64'(fired));
                    fired++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        check({name, "/done_seen"}, 64'(seen_done), 64'(1));
        check({name, "/clear_pulses"}, 64'(clr_cnt - clr0), 64'(1));
        check({name, "/idle_after"}, 64'(busy), 64'(0));
        if (expect_cnt == 0) check({name, "/no_valid"}, 64'(first_lat < 0), 64'(1));
    endtask

    task automatic load(input int n, input int t0, input int t1, input int t2, input int t3);
        int v [4];
        v[0] = t0; v[1] = t1; v[2] = t2; v[3] = t3;
        for (int i = 0; i < n; i++) set_entry(i, v[i]);
    endtask

    initial begin
        int n, clr0, waited;
        for (int i = 0; i < MAXE; i++) set_entry(i, 0);
        #2;
        check("reset/busy", 64'(busy), 64'(0));
        check("reset/done", 64'(done), 64'(0));
        check("reset/clear", 64'(sbr_clear), 64'(0));
        check("reset/valid", 64'(out_valid), 64'(0));
        check("reset/fields", dut_fields(), 64'(0));
        check("reset/rd_addr", 64'(sbr_rd_addr), 64'(0));
        check("reset/issued", 64'(issued_count), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_epoch("empty", 0, 0);
        load(3, 4, 9, 2, 0);
        run_epoch("order3", 3, 0);
        load(4, 5, 5, 5, 5);
        run_epoch("tie_hold", 4, 2);
        for (int i = 0; i < MAXE; i++) set_entry(i, (i * 37 + 11) % 256);
        run_epoch("max_entries", MAXE, 0);
        load(3, 0, 3, 0, 0);
        run_epoch("zeros", 3, 0);

        // Asynchronous reset while a descriptor is waiting for ready.
        load(3, 7, 1, 6, 0);
        @(negedge clk);
        sbr_num_entries = 3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b0;
        waited = 0;
        while (out_valid !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("rst_mid/reached_issue", 64'(out_valid), 64'(1));
        clr0 = clr_cnt;
        rst_n = 1'b0;
        #1;
        check("rst_mid/valid", 64'(out_valid), 64'(0));
        check("rst_mid/busy", 64'(busy), 64'(0));
        check("rst_mid/total", 64'(out_total), 64'(0));
        check("rst_mid/rd_addr", 64'(sbr_rd_addr), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid/no_clear", 64'(clr_cnt - clr0), 64'(0));
        run_epoch("after_reset", 3, 0);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, MAXE);
            for (int i = 0; i < n; i++)
                set_entry(i, (r % 2 == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255));
            run_epoch("random", n, (r < 2) ? 0 : 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
